// File: rtl/mm_arbiter.sv
// mm_arbiter: two-port arbiter in front of a single-port machine memory.
//   Port A (core) and port B (loader) share one memory interface. One port is
//   granted per cycle; contention is resolved round-robin unless B holds a
//   burst lock, which is bounded to MAX_LOCK consecutive grants while A waits.
//
// Ports
//   clk, rst                 clock, asynchronous active-low reset
//   a_req/a_we/a_addr/a_wdata   core request, write-enable, address, write data
//   a_gnt/a_rvalid/a_rdata      core grant, read-valid, read data
//   b_req/b_we/b_lock/b_addr/b_wdata  loader request, write-enable, burst lock,
//                                     address, write data
//   b_gnt/b_rvalid/b_rdata      loader grant, read-valid, read data
//   mm_addr/mm_we/mm_dout       memory address, write-enable, write data
//   mm_din                      memory read data, one cycle after the address
module mm_arbiter #(
    parameter int ADDR_W   = 12,
    parameter int DATA_W   = 16,
    parameter int MAX_LOCK = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              a_req,
    input  logic              a_we,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [DATA_W-1:0] a_wdata,
    output logic              a_gnt,
    output logic              a_rvalid,
    output logic [DATA_W-1:0] a_rdata,
    input  logic              b_req,
    input  logic              b_we,
    input  logic              b_lock,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [DATA_W-1:0] b_wdata,
    output logic              b_gnt,
    output logic              b_rvalid,
    output logic [DATA_W-1:0] b_rdata,
    output logic [ADDR_W-1:0] mm_addr,
    output logic              mm_we,
    output logic [DATA_W-1:0] mm_dout,
    input  logic [DATA_W-1:0] mm_din
);

    localparam logic [7:0] MAX_LOCK_C = 8'(MAX_LOCK);

    typedef enum logic {
        PORT_A = 1'b0,
        PORT_B = 1'b1
    } port_t;

    port_t             last;
    logic [7:0]        lock_cnt;
    logic              lock_hold;
    logic [ADDR_W-1:0] addr_hold;
    logic [DATA_W-1:0] dout_hold;
    logic              a_vld_p1;
    logic              b_vld_p1;
    logic [DATA_W-1:0] a_rdata_q;
    logic [DATA_W-1:0] b_rdata_q;

    // Lock counter stops at MAX_LOCK so a long uncontended burst cannot wrap.
    function automatic logic [7:0] sat_inc(input logic [7:0] cnt);
        return (cnt < MAX_LOCK_C) ? cnt + 8'd1 : cnt;
    endfunction

    // Stage p0: grant decision and memory request, combinational from inputs.
    // A non-zero lock_cnt means the previous grant was a locked B grant, so
    // B keeps the memory only while the lock is still asserted and not spent.
    always_comb begin
        a_gnt     = 1'b0;
        b_gnt     = 1'b0;
        lock_hold = (lock_cnt != 8'd0) && (lock_cnt < MAX_LOCK_C) && b_lock;
        if (rst) begin
            if (a_req && b_req) begin
                if (lock_hold || (last == PORT_A)) begin
                    b_gnt = 1'b1;
                end else begin
                    a_gnt = 1'b1;
                end
            end else begin
                a_gnt = a_req;
                b_gnt = b_req;
            end
        end
    end

    always_comb begin
        mm_addr = addr_hold;
        mm_dout = dout_hold;
        mm_we   = 1'b0;
        if (a_gnt) begin
            mm_addr = a_addr;
            mm_dout = a_wdata;
            mm_we   = a_we;
        end else if (b_gnt) begin
            mm_addr = b_addr;
            mm_dout = b_wdata;
            mm_we   = b_we;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last      <= PORT_B;
            lock_cnt  <= 8'd0;
            addr_hold <= '0;
            dout_hold <= '0;
            a_vld_p1  <= 1'b0;
            b_vld_p1  <= 1'b0;
            a_rdata_q <= '0;
            b_rdata_q <= '0;
        end else begin
            if (a_gnt) begin
                last <= PORT_A;
            end else if (b_gnt) begin
                last <= PORT_B;
            end
            lock_cnt <= (b_gnt && b_lock) ? sat_inc(lock_cnt) : 8'd0;
            if (a_gnt || b_gnt) begin
                addr_hold <= mm_addr;
                dout_hold <= mm_dout;
            end
            // Stage p1: read return, one cycle after the granted read.
            a_vld_p1 <= a_gnt && !a_we;
            b_vld_p1 <= b_gnt && !b_we;
            if (a_vld_p1) begin
                a_rdata_q <= mm_din;
            end
            if (b_vld_p1) begin
                b_rdata_q <= mm_din;
            end
        end
    end

    // Returned data passes straight through in the valid cycle and is held after.
    assign a_rvalid = a_vld_p1;
    assign b_rvalid = b_vld_p1;
    assign a_rdata  = a_vld_p1 ? mm_din : a_rdata_q;
    assign b_rdata  = b_vld_p1 ? mm_din : b_rdata_q;

endmodule

// File: tb/tb_mm_arbiter.sv
// tb_mm_arbiter: self-checking bench for mm_arbiter with a behavioural memory
// and a transaction-level reference model of the arbitration rules.
module tb_mm_arbiter;

    localparam int AW = 12;
    localparam int DW = 16;
    localparam int ML = 3;

    logic          clk;
    logic          rst;
    logic          a_req, a_we, b_req, b_we, b_lock;
    logic [AW-1:0] a_addr, b_addr, mm_addr;
    logic [DW-1:0] a_wdata, b_wdata, a_rdata, b_rdata, mm_dout, mm_din;
    logic          a_gnt, a_rvalid, b_gnt, b_rvalid, mm_we;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    mm_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_LOCK(ML)) dut (
        .clk(clk), .rst(rst),
        .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
        .a_gnt(a_gnt), .a_rvalid(a_rvalid), .a_rdata(a_rdata),
        .b_req(b_req), .b_we(b_we), .b_lock(b_lock), .b_addr(b_addr), .b_wdata(b_wdata),
        .b_gnt(b_gnt), .b_rvalid(b_rvalid), .b_rdata(b_rdata),
        .mm_addr(mm_addr), .mm_we(mm_we), .mm_dout(mm_dout), .mm_din(mm_din)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory behind the arbiter: synchronous write, read data one cycle later.
    logic [DW-1:0] mem [0:(1<<AW)-1];
    always @(posedge clk) begin
        if (mm_we) mem[mm_addr] <= mm_dout;
        mm_din <= mem[mm_addr];
    end

    // Reference model state: what memory should contain, who was served last,
    // how long B's current locked run is, and which reads are due back.
    logic [DW-1:0] shadow [0:(1<<AW)-1];
    bit            m_last_b;
    int            m_lock;
    bit            m_pa, m_pb;
    logic [DW-1:0] m_pa_d, m_pb_d, exp_ard, exp_brd;
    logic [AW-1:0] m_haddr;
    logic [DW-1:0] m_hdout;
    logic [7:0]    obs_gnt;

    task automatic model_reset();
        m_last_b = 1'b1;
        m_lock   = 0;
        m_pa     = 1'b0;
        m_pb     = 1'b0;
        exp_ard  = '0;
        exp_brd  = '0;
        m_haddr  = '0;
        m_hdout  = '0;
    endtask

    // One clock cycle: drive at posedge+1, check at negedge, advance model at posedge.
    task automatic step(input string tag,
                        input logic ar, input logic aw, input logic [AW-1:0] aa, input logic [DW-1:0] awd,
                        input logic br, input logic bw, input logic bl, input logic [AW-1:0] ba,
                        input logic [DW-1:0] bwd);
        bit            ega, egb, ewe;
        logic [AW-1:0] eaddr;
        logic [DW-1:0] edout;
        a_req = ar; a_we = aw; a_addr = aa; a_wdata = awd;
        b_req = br; b_we = bw; b_lock = bl; b_addr = ba; b_wdata = bwd;
        ega = 1'b0; egb = 1'b0;
        if (ar && br) begin
            if (bl && m_lock > 0 && m_lock < ML) egb = 1'b1;
            else if (m_last_b) ega = 1'b1;
            else egb = 1'b1;
        end else begin
            ega = ar;
            egb = br;
        end
        eaddr = ega ? aa : egb ? ba : m_haddr;
        edout = ega ? awd : egb ? bwd : m_hdout;
        ewe   = ega ? aw : egb ? bw : 1'b0;
        @(negedge clk);
        obs_gnt = a_gnt ? "A" : b_gnt ? "B" : "-";
        checks++; if (a_gnt !== ega) begin failures++; $display("FAIL %s.a_gnt cyc=%0d got=%b exp=%b", tag, cyc, a_gnt, ega); end
        checks++; if (b_gnt !== egb) begin failures++; $display("FAIL %s.b_gnt cyc=%0d got=%b exp=%b", tag, cyc, b_gnt, egb); end
        checks++; if (mm_we !== ewe) begin failures++; $display("FAIL %s.mm_we cyc=%0d got=%b exp=%b", tag, cyc, mm_we, ewe); end
        checks++; if (mm_addr !== eaddr) begin failures++; $display("FAIL %s.mm_addr cyc=%0d got=%h exp=%h", tag, cyc, mm_addr, eaddr); end
        checks++; if (mm_dout !== edout) begin failures++; $display("FAIL %s.mm_dout cyc=%0d got=%h exp=%h", tag, cyc, mm_dout, edout); end
        checks++; if (a_rvalid !== m_pa) begin failures++; $display("FAIL %s.a_rvalid cyc=%0d got=%b exp=%b", tag, cyc, a_rvalid, m_pa); end
        checks++; if (b_rvalid !== m_pb) begin failures++; $display("FAIL %s.b_rvalid cyc=%0d got=%b exp=%b", tag, cyc, b_rvalid, m_pb); end
        checks++; if (a_rdata !== (m_pa ? m_pa_d : exp_ard)) begin failures++; $display("FAIL %s.a_rdata cyc=%0d got=%h exp=%h", tag, cyc, a_rdata, m_pa ? m_pa_d : exp_ard); end
        checks++; if (b_rdata !== (m_pb ? m_pb_d : exp_brd)) begin failures++; $display("FAIL %s.b_rdata cyc=%0d got=%h exp=%h", tag, cyc, b_rdata, m_pb ? m_pb_d : exp_brd); end
        @(posedge clk);
        cyc++;
        if (m_pa) exp_ard = m_pa_d;
        if (m_pb) exp_brd = m_pb_d;
        m_pa = ega && !aw;
        m_pb = egb && !bw;
        m_pa_d = shadow[aa];
        m_pb_d = shadow[ba];
        if (ega && aw) shadow[aa] = awd;
        if (egb && bw) shadow[ba] = bwd;
        if (ega || egb) begin
            m_haddr  = eaddr;
            m_hdout  = edout;
            m_last_b = egb;
        end
        m_lock = (egb && bl) ? m_lock + 1 : 0;
        #1;
    endtask

    task automatic idle(input string tag);
        step(tag, 0, 0, '0, '0, 0, 0, 0, '0, '0);
    endtask

    // Assert reset for one cycle with requests active; every output must be 0.
    task automatic pulse_reset(input string tag);
        rst = 1'b0;
        a_req = 1; a_we = 1; a_addr = 12'h0FF; a_wdata = 16'hFFFF;
        b_req = 1; b_we = 0; b_lock = 1; b_addr = 12'h0EE; b_wdata = 16'hEEEE;
        @(negedge clk);
        checks++; if ({a_gnt, b_gnt, a_rvalid, b_rvalid, mm_we} !== 5'b0) begin failures++;
            $display("FAIL %s.ctrl_in_reset got=%b exp=00000", tag, {a_gnt, b_gnt, a_rvalid, b_rvalid, mm_we}); end
        checks++; if (mm_addr !== '0 || mm_dout !== '0) begin failures++;
            $display("FAIL %s.mm_in_reset got=%h/%h exp=0/0", tag, mm_addr, mm_dout); end
        checks++; if (a_rdata !== '0 || b_rdata !== '0) begin failures++;
            $display("FAIL %s.rdata_in_reset got=%h/%h exp=0/0", tag, a_rdata, b_rdata); end
        @(posedge clk);
        #1;
        rst = 1'b1;
        model_reset();
    endtask

    task automatic test_reset();
        pulse_reset("reset");
    endtask

    task automatic test_prefill();
        for (int i = 0; i < 64; i++)
            step("prefill", 0, 0, '0, '0, 1, 1, 0, 12'(i), 16'($urandom));
    endtask

    task automatic test_first_contended();
        logic [23:0] seq;
        seq = '0;
        pulse_reset("first_rst");
        step("first", 1, 0, 12'h010, '0, 1, 0, 0, 12'h020, '0); seq = {seq[15:0], obs_gnt};
        step("first", 0, 0, '0, '0, 1, 0, 0, 12'h020, '0);      seq = {seq[15:0], obs_gnt};
        idle("first");                                           seq = {seq[15:0], obs_gnt};
        checks++; if (seq !== "AB-") begin failures++; $display("FAIL first.seq got=%s exp=AB-", seq); end
    endtask

    task automatic test_write();
        step("write", 0, 0, '0, '0, 1, 1, 0, 12'h100, 16'h0ABC);
        idle("write");
        step("write", 1, 0, 12'h100, '0, 0, 0, 0, '0, '0);
        checks++; if (a_rvalid !== 1'b1 || a_rdata !== 16'h0ABC) begin failures++;
            $display("FAIL write.readback got=%b/%h exp=1/0abc", a_rvalid, a_rdata); end
        idle("write");
    endtask

    task automatic test_round_robin();
        logic [47:0] seq;
        seq = '0;
        step("rr", 0, 0, '0, '0, 1, 1, 0, 12'h005, 16'h5555);
        for (int i = 0; i < 6; i++) begin
            step("rr", 1, 0, 12'(i), '0, 1, 0, 0, 12'(i + 8), '0);
            seq = {seq[39:0], obs_gnt};
        end
        checks++; if (seq !== "ABABAB") begin failures++; $display("FAIL rr.seq got=%s exp=ABABAB", seq); end
        idle("rr");
    endtask

    task automatic test_lock();
        logic [63:0] seq;
        seq = '0;
        step("lock", 1, 0, 12'h003, '0, 0, 0, 0, '0, '0);
        for (int i = 0; i < 8; i++) begin
            step("lock", 1, 0, 12'(i + 16), '0, 1, 0, 1, 12'(i + 32), '0);
            seq = {seq[55:0], obs_gnt};
        end
        checks++; if (seq !== "BBBABBBA") begin failures++; $display("FAIL lock.seq got=%s exp=BBBABBBA", seq); end
        idle("lock");
    endtask

    task automatic test_lock_pulse();
        logic [31:0] seq;
        seq = '0;
        step("lockp", 0, 0, '0, '0, 1, 0, 1, 12'h021, '0);      seq = {seq[23:0], obs_gnt};
        step("lockp", 1, 0, 12'h011, '0, 1, 0, 1, 12'h022, '0); seq = {seq[23:0], obs_gnt};
        step("lockp", 0, 0, '0, '0, 1, 0, 1, 12'h023, '0);      seq = {seq[23:0], obs_gnt};
        step("lockp", 1, 0, 12'h012, '0, 1, 0, 1, 12'h024, '0); seq = {seq[23:0], obs_gnt};
        checks++; if (seq !== "BBBA") begin failures++; $display("FAIL lockp.seq got=%s exp=BBBA", seq); end
        idle("lockp");
    endtask

    task automatic test_reset_midread();
        step("midrd", 1, 0, 12'h007, '0, 0, 0, 0, '0, '0);
        pulse_reset("midrd_rst");
        idle("midrd");
        idle("midrd");
    endtask

    task automatic test_back_to_back();
        step("b2b", 1, 0, 12'h030, '0, 0, 0, 0, '0, '0);
        step("b2b", 0, 0, '0, '0, 1, 0, 0, 12'h031, '0);
        step("b2b", 1, 0, 12'h032, '0, 0, 0, 0, '0, '0);
        idle("b2b");
        idle("b2b");
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++)
            step("rand",
                 $urandom_range(0, 99) < 55, $urandom_range(0, 3) == 0, 12'($urandom_range(0, 63)), 16'($urandom),
                 $urandom_range(0, 99) < 60, $urandom_range(0, 3) == 0, $urandom_range(0, 1) == 1,
                 12'($urandom_range(0, 63)), 16'($urandom));
        idle("rand");
    endtask

    initial begin
        rst = 1'b0;
        a_req = 0; a_we = 0; a_addr = '0; a_wdata = '0;
        b_req = 0; b_we = 0; b_lock = 0; b_addr = '0; b_wdata = '0;
        model_reset();
        @(posedge clk);
        #1;
        test_reset();
        test_prefill();
        test_first_contended();
        test_write();
        test_round_robin();
        test_lock();
        test_lock_pulse();
        test_reset_midread();
        test_back_to_back();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
